// File: rtl/adder_seq_if.sv
// adder_seq_if: operand, control and result bundle for adder_seq.
// The sub signal exists only when ADDER_SEQ_SUB_EN is defined.
interface adder_seq_if;
   logic [31:0] a;
   logic [31:0] b;
   logic        ci;
   logic        start;
`ifdef ADDER_SEQ_SUB_EN
   logic        sub;
`endif
   logic        busy;
   logic        done;
   logic [31:0] s;
   logic        co;
   logic        ov;

   modport master (
`ifdef ADDER_SEQ_SUB_EN
      output sub,
`endif
      output a, b, ci, start,
      input  busy, done, s, co, ov
   );

   modport slave (
`ifdef ADDER_SEQ_SUB_EN
      input  sub,
`endif
      input  a, b, ci, start,
      output busy, done, s, co, ov
   );
endinterface

// File: rtl/adder_seq.sv
// adder_seq: 32-bit add done as four 8-bit ripple slices, LSB byte first.
// Define ADDER_SEQ_SUB_EN to add a sub input that computes a - b.
module adder_seq (
   input  logic       clk,
   input  logic       rst,
   adder_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        load;
   logic [1:0]  cnt;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic        carry;
   logic [31:0] s_r;
   logic        co_r;
   logic        ov_r;
   logic [31:0] b_eff;
   logic        c_eff;
   logic [7:0]  a_byte;
   logic [7:0]  b_byte;
   logic [8:0]  slice;

`ifdef ADDER_SEQ_SUB_EN
   assign b_eff = bus.sub ? ~bus.b : bus.b;
   assign c_eff = bus.sub | bus.ci;
`else
   assign b_eff = bus.b;
   assign c_eff = bus.ci;
`endif

   assign a_byte = a_r[{cnt, 3'b000} +: 8];
   assign b_byte = b_r[{cnt, 3'b000} +: 8];
   assign slice  = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};

   assign bus.busy = (state == CALC);
   assign bus.done = (state == DONE);
   assign bus.s    = s_r;
   assign bus.co   = co_r;
   assign bus.ov   = ov_r;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and operand-load decision; start is ignored in CALC
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            if (cnt == 2'd3) state_nx = DONE;
         end
         DONE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = CALC;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch and one slice per CALC cycle; carry kept in a register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 2'd0;
         a_r   <= 32'd0;
         b_r   <= 32'd0;
         carry <= 1'b0;
         s_r   <= 32'd0;
         co_r  <= 1'b0;
         ov_r  <= 1'b0;
      end else if (load) begin
         a_r   <= bus.a;
         b_r   <= b_eff;
         carry <= c_eff;
         cnt   <= 2'd0;
      end else if (state == CALC) begin
         s_r[{cnt, 3'b000} +: 8] <= slice[7:0];
         carry <= slice[8];
         cnt   <= cnt + 2'd1;
         if (cnt == 2'd3) begin
            co_r <= slice[8];
            ov_r <= (a_r[31] == b_r[31]) && (slice[7] != a_r[31]);
         end
      end
   end
endmodule
